stream_minmax_tracker: RTL and testbench

// - Sequential consumer of magnitude-compare results (agb/alb/aeb): accepts a framed stream of

---
 rtl/minmax_pkg.sv | 7 +
 rtl/mag_cmp_n.sv | 15 +
 rtl/stream_minmax_tracker.sv | 91 +++++++++
 tb/tb_stream_minmax_tracker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// minmax_pkg: shared state encoding and default sizing for the min/max stream tracker
package minmax_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam int MAX_LEN_DEF = 8;
  localparam int IDX_W = $clog2(MAX_LEN_DEF);
  localparam int CNT_W = $clog2(MAX_LEN_DEF + 1);
endpackage

// File: rtl/mag_cmp_n.sv
// mag_cmp_n: combinational WIDTH-bit magnitude comparator, signed or unsigned
module mag_cmp_n #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             agb,
  output logic             alb,
  output logic             aeb
);
  assign agb = SIGNED ? ($signed(a) > $signed(b)) : (a > b);
  assign alb = SIGNED ? ($signed(a) < $signed(b)) : (a < b);
  assign aeb = a == b;
endmodule

// File: rtl/stream_minmax_tracker.sv
// stream_minmax_tracker: accumulates min/max (first index), count and all-equal over a framed
// sample stream and hands the registered result downstream over valid/ready.
module stream_minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter bit SIGNED  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_min,
  output logic [WIDTH-1:0]             out_max,
  output logic [$clog2(MAX_LEN)-1:0]   out_min_idx,
  output logic [$clog2(MAX_LEN)-1:0]   out_max_idx,
  output logic [$clog2(MAX_LEN+1)-1:0] out_count,
  output logic                         out_all_equal,
  output logic                         out_trunc
);
  localparam int IW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);
  state_t r_state;
  logic r_rdy, r_ov, r_ae, r_trunc;
  logic [WIDTH-1:0] r_min, r_max;
  logic [IW-1:0] r_min_idx, r_max_idx;
  logic [CW-1:0] r_count;
  logic w_max_gt, w_max_lt, w_max_eq, w_min_gt, w_min_lt, w_min_eq;
  logic w_acc, w_first, w_close, w_keep_eq;
  logic [CW-1:0] w_cnt;
  mag_cmp_n #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_max (
    .a(in_data), .b(r_max), .agb(w_max_gt), .alb(w_max_lt), .aeb(w_max_eq)
  );
  mag_cmp_n #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_min (
    .a(in_data), .b(r_min), .agb(w_min_gt), .alb(w_min_lt), .aeb(w_min_eq)
  );
  assign w_acc     = in_valid & r_rdy;
  assign w_first   = r_state == IDLE;
  assign w_cnt     = w_first ? CW'(1) : r_count + CW'(1);
  assign w_close   = in_last | (w_cnt == CW'(MAX_LEN));
  assign w_keep_eq = w_max_eq & w_min_eq & ~w_max_lt & ~w_min_gt;
  // The result registers double as accumulators; they only move on an accept, so they hold in HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rdy     <= 1'b0;
      r_ov      <= 1'b0;
      r_min     <= '0;
      r_max     <= '0;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_count   <= '0;
      r_ae      <= 1'b0;
      r_trunc   <= 1'b0;
    end else if (r_state == HOLD) begin
      if (out_ready) begin
        r_state <= IDLE;
        r_ov    <= 1'b0;
        r_rdy   <= 1'b1;
      end
    end else begin
      r_rdy <= 1'b1;
      if (w_acc) begin
        r_max     <= (w_first | w_max_gt) ? in_data : r_max;
        r_max_idx <= w_first ? '0 : (w_max_gt ? r_count[IW-1:0] : r_max_idx);
        r_min     <= (w_first | w_min_lt) ? in_data : r_min;
        r_min_idx <= w_first ? '0 : (w_min_lt ? r_count[IW-1:0] : r_min_idx);
        r_ae      <= w_first | (r_ae & w_keep_eq);
        r_count   <= w_cnt;
        r_state   <= w_close ? HOLD : ACCUM;
        r_ov      <= w_close;
        r_rdy     <= ~w_close;
        r_trunc   <= w_close ? ~in_last : r_trunc;
      end
    end
  end
  assign in_ready      = r_rdy;
  assign out_valid     = r_ov;
  assign out_min       = r_min;
  assign out_max       = r_max;
  assign out_min_idx   = r_min_idx;
  assign out_max_idx   = r_max_idx;
  assign out_count     = r_count;
  assign out_all_equal = r_ae;
  assign out_trunc     = r_trunc;
endmodule

// File: tb/tb_stream_minmax_tracker.sv
// tb_stream_minmax_tracker: directed and random frames into unsigned and signed trackers sharing one stream
module tb_stream_minmax_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iv = 1'b0, il = 1'b0, ordy = 1'b0;
  logic [3:0] id = '0;
  logic ir, ov, oae, otr, s_ir, s_ov, s_ae, s_tr;
  logic [3:0] omin, omax, ocnt, s_min, s_max, s_cnt;
  logic [2:0] omi, oxi, s_mi, s_xi;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  stream_minmax_tracker #(.WIDTH(4), .MAX_LEN(8), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_data(id), .in_last(il),
    .out_valid(ov), .out_ready(ordy), .out_min(omin), .out_max(omax), .out_min_idx(omi),
    .out_max_idx(oxi), .out_count(ocnt), .out_all_equal(oae), .out_trunc(otr)
  );
  stream_minmax_tracker #(.WIDTH(4), .MAX_LEN(8), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(s_ir), .in_data(id), .in_last(il),
    .out_valid(s_ov), .out_ready(ordy), .out_min(s_min), .out_max(s_max), .out_min_idx(s_mi),
    .out_max_idx(s_xi), .out_count(s_cnt), .out_all_equal(s_ae), .out_trunc(s_tr)
  );
  function automatic int val(input logic [3:0] x, input bit sgn);
    return sgn ? int'($signed(x)) : int'(x);
  endfunction
  // Reference: first-occurrence extremes, length and all-equal computed straight from the sample list.
  function automatic void ref_model(input logic [3:0] q[$], input bit sgn,
      output logic [3:0] mn, output logic [3:0] mx, output int mni, output int mxi,
      output bit alleq);
    mn = q[0]; mx = q[0]; mni = 0; mxi = 0; alleq = 1'b1;
    for (int i = 1; i < q.size(); i++) begin
      if (val(q[i], sgn) < val(mn, sgn)) begin mn = q[i]; mni = i; end
      if (val(q[i], sgn) > val(mx, sgn)) begin mx = q[i]; mxi = i; end
      if (q[i] != q[0]) alleq = 1'b0;
    end
  endfunction
  task automatic send(input logic [3:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    iv = 1'b1; id = d; il = l;
    while (!ir && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (ir !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", ir);
    end
    @(posedge clk);
    #1 iv = 1'b0; il = 1'b0;
  endtask
  task automatic take();
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({ir, ov, omin, omax, omi, oxi, ocnt, oae, otr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ir=%b ov=%b min=%h max=%h mi=%0d xi=%0d cnt=%0d ae=%b tr=%b required all 0",
               ir, ov, omin, omax, omi, oxi, ocnt, oae, otr);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise: in_ready=%b required 1", ir); end
  endtask
  task automatic test_basic();
    send(4'd3, 1'b0); send(4'd9, 1'b0); send(4'd1, 1'b0); send(4'd9, 1'b0);
    n_chk++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: out_valid=%b required 0", ov); end
    send(4'd5, 1'b1);
    n_chk++;
    if ({ov, ir} !== 2'b10) begin n_fail++; $display("FAIL basic_latency: ov=%b ir=%b required 1 0", ov, ir); end
    n_chk++;
    if ({omin, omi, omax, oxi, ocnt, oae, otr} !== {4'd1, 3'd2, 4'd9, 3'd1, 4'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: min=%0d/%0d max=%0d/%0d cnt=%0d ae=%b tr=%b required 1/2 9/1 5 0 0",
               omin, omi, omax, oxi, ocnt, oae, otr);
    end
    take();
    n_chk++;
    if ({ov, ir} !== 2'b01) begin n_fail++; $display("FAIL basic_release: ov=%b ir=%b required 0 1", ov, ir); end
  endtask
  task automatic test_single();
    send(4'd7, 1'b1);
    n_chk++;
    if ({ov, omin, omi, omax, oxi, ocnt, oae, otr} !== {1'b1, 4'd7, 3'd0, 4'd7, 3'd0, 4'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_result: ov=%b min=%0d/%0d max=%0d/%0d cnt=%0d ae=%b tr=%b required 1 7/0 7/0 1 1 0",
               ov, omin, omi, omax, oxi, ocnt, oae, otr);
    end
    take();
  endtask
  task automatic test_trunc();
    for (int i = 0; i < 8; i++) send(4'd6, 1'b0);
    n_chk++;
    if ({ov, ir, ocnt, oae, otr, omin, omax} !== {1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 4'd6, 4'd6}) begin
      n_fail++;
      $display("FAIL trunc_result: ov=%b ir=%b cnt=%0d ae=%b tr=%b min=%0d max=%0d required 1 0 8 1 1 6 6",
               ov, ir, ocnt, oae, otr, omin, omax);
    end
    take();
  endtask
  task automatic test_backpressure();
    send(4'd2, 1'b0); send(4'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv = 1'($urandom_range(0, 1)); id = 4'($urandom); il = 1'($urandom_range(0, 1));
      n_chk++;
      if ({ov, ir, omin, omax, ocnt, omi, oxi} !== {1'b1, 1'b0, 4'd2, 4'd5, 4'd2, 3'd0, 3'd1}) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: ov=%b ir=%b min=%0d max=%0d cnt=%0d mi=%0d xi=%0d required 1 0 2 5 2 0 1",
                 i, ov, ir, omin, omax, ocnt, omi, oxi);
      end
    end
    @(negedge clk);
    iv = 1'b0; il = 1'b0;
    take();
    n_chk++;
    if ({ov, ir} !== 2'b01) begin n_fail++; $display("FAIL bp_release: ov=%b ir=%b required 0 1", ov, ir); end
    send(4'd4, 1'b1);
    n_chk++;
    if ({ocnt, omin, omax} !== {4'd1, 4'd4, 4'd4}) begin
      n_fail++;
      $display("FAIL bp_nothing_absorbed: cnt=%0d min=%0d max=%0d required 1 4 4", ocnt, omin, omax);
    end
    take();
  endtask
  task automatic test_signed();
    send(4'hF, 1'b0); send(4'h2, 1'b0); send(4'h8, 1'b1);
    n_chk++;
    if ({s_ov, s_min, s_mi, s_max, s_xi, s_cnt, s_ae} !== {1'b1, 4'h8, 3'd2, 4'h2, 3'd1, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL signed_result: ov=%b min=%h/%0d max=%h/%0d cnt=%0d ae=%b required 1 8/2 2/1 3 0",
               s_ov, s_min, s_mi, s_max, s_xi, s_cnt, s_ae);
    end
    n_chk++;
    if ({omin, omi, omax, oxi} !== {4'h2, 3'd1, 4'hF, 3'd0}) begin
      n_fail++;
      $display("FAIL signed_unsigned_view: min=%h/%0d max=%h/%0d required 2/1 f/0", omin, omi, omax, oxi);
    end
    take();
  endtask
  task automatic test_midreset();
    send(4'd1, 1'b0); send(4'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if ({ov, ir, ocnt} !== {1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL midreset_clear: ov=%b ir=%b cnt=%0d required 0 0 0", ov, ir, ocnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd4, 1'b1);
    n_chk++;
    if ({ov, ocnt, omin, omax, oae} !== {1'b1, 4'd1, 4'd4, 4'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_fresh: ov=%b cnt=%0d min=%0d max=%0d ae=%b required 1 1 4 4 1", ov, ocnt, omin, omax, oae);
    end
    take();
  endtask
  task automatic test_random();
    logic [3:0] q[$];
    logic [3:0] mn, mx;
    int mni, mxi;
    bit ae, l;
    for (int f = 0; f < 40; f++) begin
      q.delete();
      l = 1'b0;
      while (!l && q.size() < 8) begin
        logic [3:0] d;
        d = (f % 4 == 0) ? 4'd11 : 4'($urandom);
        l = ($urandom_range(0, 4) == 0);
        send(d, l);
        q.push_back(d);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ref_model(q, 1'b0, mn, mx, mni, mxi, ae);
      n_chk++;
      if ({ov, omin, omi, omax, oxi, ocnt, oae, otr} !==
          {1'b1, mn, 3'(mni), mx, 3'(mxi), 4'(q.size()), ae, !l}) begin
        n_fail++;
        $display("FAIL rand_unsigned f%0d: ov=%b min=%h/%0d max=%h/%0d cnt=%0d ae=%b tr=%b required 1 %h/%0d %h/%0d %0d %b %b",
                 f, ov, omin, omi, omax, oxi, ocnt, oae, otr, mn, mni, mx, mxi, q.size(), ae, !l);
      end
      ref_model(q, 1'b1, mn, mx, mni, mxi, ae);
      n_chk++;
      if ({s_ov, s_min, s_mi, s_max, s_xi, s_cnt, s_ae, s_tr} !==
          {1'b1, mn, 3'(mni), mx, 3'(mxi), 4'(q.size()), ae, !l}) begin
        n_fail++;
        $display("FAIL rand_signed f%0d: ov=%b min=%h/%0d max=%h/%0d cnt=%0d ae=%b tr=%b required 1 %h/%0d %h/%0d %0d %b %b",
                 f, s_ov, s_min, s_mi, s_max, s_xi, s_cnt, s_ae, s_tr, mn, mni, mx, mxi, q.size(), ae, !l);
      end
      take();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_single();
    test_trunc();
    test_backpressure();
    test_signed();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
